// File: rtl/systolic_pkg.sv
// systolic_pkg: shared constants, element type and feeder state encoding for the systolic array
package systolic_pkg;
    localparam int DATA_WIDTH  = 16;
    localparam int N           = 4;
    localparam int FEED_CYCLES = 2 * N - 1;
    typedef logic signed [DATA_WIDTH-1:0] elem_t;
    typedef enum logic {LOAD, FEED} state_t;
endpackage

// File: rtl/skew_tile_buffer.sv
// skew_tile_buffer: 4x4 A/B tile store with beat-indexed write and diagonally skewed read at step t
module skew_tile_buffer
    import systolic_pkg::*;
(
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [1:0]              wr_idx,
    input  logic [N*DATA_WIDTH-1:0] a_row,
    input  logic [N*DATA_WIDTH-1:0] b_col,
    input  logic [2:0]              t,
    output logic [N*DATA_WIDTH-1:0] a_skew,
    output logic [N*DATA_WIDTH-1:0] b_skew
);
    elem_t a_mem [N][N];
    elem_t b_mem [N][N];
    // beat k carries row k of A and column k of B
    always_ff @(posedge clk)
        if (wr_en)
            for (int k = 0; k < N; k++) begin
                a_mem[wr_idx][k] <= a_row[k*DATA_WIDTH +: DATA_WIDTH];
                b_mem[k][wr_idx] <= b_col[k*DATA_WIDTH +: DATA_WIDTH];
            end
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [3:0] d;
        logic       hit;
        assign d   = {1'b0, t} - 4'(i);
        assign hit = d < 4'(N);
        assign a_skew[i*DATA_WIDTH +: DATA_WIDTH] = hit ? a_mem[i][d[1:0]] : '0;
        assign b_skew[i*DATA_WIDTH +: DATA_WIDTH] = hit ? b_mem[d[1:0]][i] : '0;
    end
endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: loads A/B tiles in four beats and emits skewed west/north wavefronts; SYSTOLIC_SKEW_FEEDER_DBUF_EN enables a second bank for back-to-back tiles
module systolic_skew_feeder
    import systolic_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] in_a_row,
    input  logic [N*DATA_WIDTH-1:0] in_b_col,
    output logic                    out_valid,
    output logic [N*DATA_WIDTH-1:0] a_west,
    output logic [N*DATA_WIDTH-1:0] b_north,
    output logic                    tile_start,
    output logic                    tile_done
);
    state_t                  state, nxt_state;
    logic [1:0]              load_cnt;
    logic [2:0]              feed_cnt, nxt_t;
    logic                    accept, last_beat, feed_end, full_now, start, nxt_valid, nxt_ready;
    logic [N*DATA_WIDTH-1:0] rd_a, rd_b;
    assign accept    = in_valid && in_ready;
    assign last_beat = accept && load_cnt == 2'd3;
    assign feed_end  = state == FEED && feed_cnt == 3'(FEED_CYCLES - 1);
`ifdef SYSTOLIC_SKEW_FEEDER_DBUF_EN
    logic                    wr_bank, rd_bank, full, nxt_rd;
    logic [N*DATA_WIDTH-1:0] a0, b0, a1, b1;
    assign full_now  = full || last_beat;
    assign nxt_rd    = start ? wr_bank : rd_bank;
    assign nxt_ready = start || !full_now;
    assign rd_a      = nxt_rd ? a1 : a0;
    assign rd_b      = nxt_rd ? b1 : b0;
    skew_tile_buffer u_buf0 (
        .clk(clk), .wr_en(accept && !wr_bank), .wr_idx(load_cnt), .a_row(in_a_row),
        .b_col(in_b_col), .t(nxt_t), .a_skew(a0), .b_skew(b0)
    );
    skew_tile_buffer u_buf1 (
        .clk(clk), .wr_en(accept && wr_bank), .wr_idx(load_cnt), .a_row(in_a_row),
        .b_col(in_b_col), .t(nxt_t), .a_skew(a1), .b_skew(b1)
    );
    // swap banks when a tile starts; idle bank becomes full on its fourth beat
    always_ff @(posedge clk)
        if (rst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            full    <= 1'b0;
        end else if (start) begin
            rd_bank <= wr_bank;
            wr_bank <= !wr_bank;
            full    <= 1'b0;
        end else if (last_beat)
            full <= 1'b1;
`else
    assign full_now  = last_beat;
    assign nxt_ready = nxt_state == LOAD;
    skew_tile_buffer u_buf (
        .clk(clk), .wr_en(accept), .wr_idx(load_cnt), .a_row(in_a_row),
        .b_col(in_b_col), .t(nxt_t), .a_skew(rd_a), .b_skew(rd_b)
    );
`endif
    // next-cycle sequencing; the wavefront for nxt_t is read ahead so outputs can be registered
    always_comb begin
        start     = (state == LOAD || feed_end) && full_now;
        nxt_state = start ? FEED : feed_end ? LOAD : state;
        nxt_t     = (state == FEED && !feed_end) ? feed_cnt + 3'd1 : 3'd0;
        nxt_valid = nxt_state == FEED;
    end
    // state, counters and registered outputs; lanes forced to zero outside valid cycles
    always_ff @(posedge clk)
        if (rst) begin
            state      <= LOAD;
            load_cnt   <= '0;
            feed_cnt   <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            a_west     <= '0;
            b_north    <= '0;
            tile_start <= 1'b0;
            tile_done  <= 1'b0;
        end else begin
            state      <= nxt_state;
            feed_cnt   <= nxt_t;
            load_cnt   <= accept ? load_cnt + 2'd1 : load_cnt;
            in_ready   <= nxt_ready;
            out_valid  <= nxt_valid;
            a_west     <= nxt_valid ? rd_a : '0;
            b_north    <= nxt_valid ? rd_b : '0;
            tile_start <= start;
            tile_done  <= nxt_valid && nxt_t == 3'(FEED_CYCLES - 1);
        end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: directed checks of load, skewed feed, framing, reset and data integrity
module tb_systolic_skew_feeder;
    import systolic_pkg::*;
    localparam int W = N * DATA_WIDTH;
    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, tile_start, tile_done;
    logic [W-1:0] in_a_row, in_b_col, a_west, b_north;
    int           checks = 0;
    int           errors = 0;
    logic [DATA_WIDTH-1:0] am [2][N][N];
    logic [DATA_WIDTH-1:0] bm [2][N][N];
    logic [W-1:0] ea [2][7];
    logic [W-1:0] eb [2][7];

    always #5 clk = ~clk;

    systolic_skew_feeder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a_row(in_a_row), .in_b_col(in_b_col), .out_valid(out_valid),
        .a_west(a_west), .b_north(b_north), .tile_start(tile_start), .tile_done(tile_done)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        in_valid = 1'b0;
        in_a_row = {4{16'hDEAD}};
        in_b_col = {4{16'hBEEF}};
    endtask

    task automatic drive(input int s, input int k);
        in_valid = 1'b1;
        for (int c = 0; c < N; c++) begin
            in_a_row[c*DATA_WIDTH +: DATA_WIDTH] = am[s][k][c];
            in_b_col[c*DATA_WIDTH +: DATA_WIDTH] = bm[s][c][k];
        end
    endtask

    // four beats; with gap, an idle cycle follows each of the first three beats
    task automatic load(input int s, input bit gap);
        for (int k = 0; k < N; k++) begin
            check($sformatf("load_ready_k%0d", k), in_ready, 1);
            drive(s, k);
            tick;
            if (k < N - 1) begin
                check($sformatf("load_nofeed_k%0d", k), out_valid, 0);
                if (gap) begin
                    idle;
                    tick;
                    check($sformatf("gap_nofeed_k%0d", k), out_valid, 0);
                end
            end
        end
    endtask

    // checks the seven wavefronts of tile s; nxt >= 0 streams that tile's beats meanwhile
    task automatic feed(input int s, input int nxt, input bit last);
        for (int t = 0; t < FEED_CYCLES; t++) begin
            if (nxt >= 0) begin
                if (t < N) drive(nxt, t);
                else idle;
            end
            check($sformatf("s%0d_valid_t%0d", s, t), out_valid, 1);
            check($sformatf("s%0d_a_t%0d", s, t), a_west, ea[s][t]);
            check($sformatf("s%0d_b_t%0d", s, t), b_north, eb[s][t]);
            check($sformatf("s%0d_start_t%0d", s, t), tile_start, W'(t == 0));
            check($sformatf("s%0d_done_t%0d", s, t), tile_done, W'(t == FEED_CYCLES - 1));
`ifndef SYSTOLIC_SKEW_FEEDER_DBUF_EN
            check($sformatf("s%0d_ready_t%0d", s, t), in_ready, 0);
`endif
            tick;
        end
        if (last) begin
            check("end_valid", out_valid, 0);
            check("end_a_zero", a_west, 0);
            check("end_b_zero", b_north, 0);
            check("end_ready", in_ready, 1);
            check("end_done", tile_done, 0);
        end
    endtask

    initial begin
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                am[0][r][c] = 16'(10 * r + c);
                bm[0][r][c] = 16'(100 * r + c);
                am[1][r][c] = 16'hFFFF;
                bm[1][r][c] = 16'h8000;
            end
        ea[0][0] = 64'h0000_0000_0000_0000; eb[0][0] = 64'h0000_0000_0000_0000;
        ea[0][1] = 64'h0000_0000_000A_0001; eb[0][1] = 64'h0000_0000_0001_0064;
        ea[0][2] = 64'h0000_0014_000B_0002; eb[0][2] = 64'h0000_0002_0065_00C8;
        ea[0][3] = 64'h001E_0015_000C_0003; eb[0][3] = 64'h0003_0066_00C9_012C;
        ea[0][4] = 64'h001F_0016_000D_0000; eb[0][4] = 64'h0067_00CA_012D_0000;
        ea[0][5] = 64'h0020_0017_0000_0000; eb[0][5] = 64'h00CB_012E_0000_0000;
        ea[0][6] = 64'h0021_0000_0000_0000; eb[0][6] = 64'h012F_0000_0000_0000;
        ea[1][0] = 64'h0000_0000_0000_FFFF; eb[1][0] = 64'h0000_0000_0000_8000;
        ea[1][1] = 64'h0000_0000_FFFF_FFFF; eb[1][1] = 64'h0000_0000_8000_8000;
        ea[1][2] = 64'h0000_FFFF_FFFF_FFFF; eb[1][2] = 64'h0000_8000_8000_8000;
        ea[1][3] = 64'hFFFF_FFFF_FFFF_FFFF; eb[1][3] = 64'h8000_8000_8000_8000;
        ea[1][4] = 64'hFFFF_FFFF_FFFF_0000; eb[1][4] = 64'h8000_8000_8000_0000;
        ea[1][5] = 64'hFFFF_FFFF_0000_0000; eb[1][5] = 64'h8000_8000_0000_0000;
        ea[1][6] = 64'hFFFF_0000_0000_0000; eb[1][6] = 64'h8000_0000_0000_0000;
        rst = 1'b1;
        idle;
        tick;
        tick;
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_a", a_west, 0);
        check("rst_b", b_north, 0);
        check("rst_start", tile_start, 0);
        check("rst_done", tile_done, 0);
        rst = 1'b0;
        load(0, 1'b0);
        idle;
        feed(0, -1, 1'b1);
        load(1, 1'b1);
        idle;
        feed(1, -1, 1'b1);
`ifndef SYSTOLIC_SKEW_FEEDER_DBUF_EN
        load(0, 1'b0);
        in_valid = 1'b1;
        in_a_row = {4{16'h1234}};
        in_b_col = {4{16'h5678}};
        feed(0, -1, 1'b1);
        idle;
        load(1, 1'b0);
        idle;
        feed(1, -1, 1'b1);
`endif
        load(0, 1'b0);
        idle;
        tick;
        tick;
        tick;
        check("pre_rst_a_t3", a_west, ea[0][3]);
        rst = 1'b1;
        drive(1, 0);
        tick;
        rst = 1'b0;
        idle;
        check("midrst_valid", out_valid, 0);
        check("midrst_a", a_west, 0);
        check("midrst_b", b_north, 0);
        check("midrst_ready", in_ready, 1);
        check("midrst_done", tile_done, 0);
        tick;
        check("midrst_done2", tile_done, 0);
        check("midrst_valid2", out_valid, 0);
        load(0, 1'b0);
        idle;
        feed(0, -1, 1'b1);
`ifdef SYSTOLIC_SKEW_FEEDER_DBUF_EN
        load(0, 1'b0);
        idle;
        feed(0, 1, 1'b0);
        feed(1, -1, 1'b1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Upstream feeder for the 4x4 systolic PE array. Accepts one 4x4 A tile and one 4x4 B tile as four row/column beats over a valid/ready port, buffers them, then emits the diagonally skewed west-edge (A) and north-edge (B) wavefronts the array consumes, zero-padded, over 7 cycles per tile. Also produces tile framing pulses so the array can clear and harvest its partial sums.

## Interface
- DATA_WIDTH, 16, signed element width; matches the array's DATA_WIDTH
- N, 4, array dimension; fixed at 4, present for package constants only
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  load beat valid
- in_ready  output  1  feeder can accept a load beat
- in_a_row  input  4*DATA_WIDTH  beat k: A[k][c] at bits [c*DATA_WIDTH +: DATA_WIDTH]
- in_b_col  input  4*DATA_WIDTH  beat k: B[r][k] at bits [r*DATA_WIDTH +: DATA_WIDTH]
- out_valid  output  1  wavefront valid this cycle
- a_west  output  4*DATA_WIDTH  lane i drives array row i west input
- b_north  output  4*DATA_WIDTH  lane j drives array column j north input
- tile_start  output  1  one-cycle pulse with first wavefront of a tile
- tile_done  output  1  one-cycle pulse with last wavefront of a tile

## Operation
- States: LOAD, FEED. Reset state LOAD.
- LOAD: in_ready=1; beat accepted when in_valid&&in_ready; load_cnt 0..3 selects buffer row/column. Accepting beat 3 moves to FEED, load_cnt wraps to 0.
- FEED: feed_cnt t = 0..6. a_west[i] = A[i][t-i] when 0 <= t-i <= 3, else 0. b_north[j] = B[t-j][j] when 0 <= t-j <= 3, else 0. out_valid=1 all 7 cycles; tile_start at t=0, tile_done at t=6.
- After t=6: return to LOAD (no DBUF) or continue per Configuration.
- No arithmetic; data passed bit-exact, signed, no width change.
- No backpressure from the array; FEED never stalls.
- in_valid while in_ready=0 is ignored; data must be held by sender.
- Output data lanes are forced to 0 whenever out_valid=0.

## Timing
- Reset values: in_ready=1, out_valid=0, a_west=0, b_north=0, tile_start=0, tile_done=0; counters 0; buffer contents undefined (never visible).
- Reset mid-LOAD or mid-FEED: next cycle in LOAD, partial tile discarded, no tile_done.
- Latency: beat 3 accepted at edge n -> first wavefront (tile_start) registered output at cycle n+1; tile_done at n+7.
- All outputs are registered.
- Without DBUF: in_ready=0 during FEED; first new beat accepted earliest at cycle n+8. Throughput 11 cycles/tile minimum.
- Simultaneous in_valid and reset: reset wins, beat dropped.

## Configuration
- SYSTOLIC_SKEW_FEEDER_DBUF_EN defined: two buffer banks. Loading targets the idle bank; in_ready=1 during FEED while idle bank not full. If idle bank full at t=6, banks swap and next tile's t=0 follows the previous t=6 on the next cycle (back-to-back, out_valid continuous, tile_done and tile_start on consecutive cycles). Otherwise return to LOAD/wait; FEED starts the cycle after the idle bank's beat 3.
- Undefined: single bank, behaviour as above.

## Structure
- Shared package systolic_pkg: DATA_WIDTH, N, FEED_CYCLES = 2*N-1, element typedef (logic signed [DATA_WIDTH-1:0]), state enum {LOAD, FEED}.
- One sub-module: skew_tile_buffer (4x4 register bank with row write and skewed read at index t); instantiated once, or twice under DBUF.

## Test plan
- Reset, then A[r][c]=10r+c, B[r][c]=100r+c loaded in 4 back-to-back beats -> t=0: a_west={0,0,0,0 except lane0=0}, b_north lane0=0; t=3: a_west={3,12,21,30}, b_north={300,201,102,3}; t=6: a_west lane3=33, others 0; tile_done at t=6.
- in_valid toggling 1,0,1,0 during LOAD -> only valid beats counted; FEED starts cycle after 4th accepted beat.
- in_valid held high during FEED (no DBUF) -> in_ready=0, no beats accepted until LOAD.
- Assert rst at feed t=3 -> next cycle out_valid=0, all lanes 0, in_ready=1, no tile_done.
- Negative data: A all -1 (0xFFFF), B all -32768 -> lanes reproduce values bit-exact in valid skew slots, 0 elsewhere.
- DBUF: stream two tiles continuously -> out_valid high 14 consecutive cycles, tile_done then tile_start on adjacent cycles.
